// File: rtl/mem_access_ctrl.sv
// Load/store engine between the MEM stage and the RAM/ROM data port.
// Big-endian lane steering, wait-state counting, misalign and timeout.
module mem_access_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int TIMEOUT     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_signed_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_done_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic        stall_req_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i,
  input  logic        ram_ready_i
);

  localparam int CW = $clog2(WAIT_CYCLES + TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_W = CW'(WAIT_CYCLES - 1);
  localparam logic [CW-1:0] LAST_S = CW'(WAIT_CYCLES + TIMEOUT - 2);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [1:0]    size_q, size_d;
  logic          sgn_q, sgn_d;
  logic [1:0]    off_q, off_d;

  logic          ce_d, wen_d;
  logic [31:0]   addr_d, data_d, rdata_d;
  logic [3:0]    sel_d;
  logic          done_d, mis_d, berr_d;

  logic          req_mis;
  logic [3:0]    req_sel;
  logic [31:0]   req_data;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   ld_val;

  assign stall_req_o = mem_req_i & ~mem_done_o;

  always_comb begin
    req_mis  = 1'b0;
    req_sel  = 4'b1111;
    req_data = mem_wdata_i;
    unique case (1'b1)
      (mem_size_i == 2'b00): begin
        req_sel  = 4'b1000 >> mem_addr_i[1:0];
        req_data = {4{mem_wdata_i[7:0]}};
      end
      (mem_size_i == 2'b01): begin
        req_mis  = mem_addr_i[0];
        req_sel  = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        req_data = {2{mem_wdata_i[15:0]}};
      end
      default: begin
        req_mis  = |mem_addr_i[1:0];
      end
    endcase
  end

  always_comb begin
    unique case (off_q)
      2'd0:    lane_b = ram_data_i[31:24];
      2'd1:    lane_b = ram_data_i[23:16];
      2'd2:    lane_b = ram_data_i[15:8];
      default: lane_b = ram_data_i[7:0];
    endcase
    lane_h = off_q[1] ? ram_data_i[15:0] : ram_data_i[31:16];
    unique case (size_q)
      2'b00:   ld_val = {{24{sgn_q & lane_b[7]}}, lane_b};
      2'b01:   ld_val = {{16{sgn_q & lane_h[15]}}, lane_h};
      default: ld_val = ram_data_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    off_d   = off_q;
    ce_d    = 1'b0;
    wen_d   = 1'b0;
    addr_d  = '0;
    sel_d   = '0;
    data_d  = '0;
    rdata_d = '0;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    berr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_req_i) begin
          if (req_mis) begin
            state_d = RESP;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d = ACCESS;
            cnt_d   = '0;
            we_d    = mem_we_i;
            size_d  = mem_size_i;
            sgn_d   = mem_signed_i;
            off_d   = mem_addr_i[1:0];
            ce_d    = 1'b1;
            wen_d   = mem_we_i && (WAIT_CYCLES == 1);
            addr_d  = {mem_addr_i[31:2], 2'b00};
            sel_d   = req_sel;
            data_d  = req_data;
          end
        end
      end
      ACCESS: begin
        cnt_d  = cnt_q + 1'b1;
        addr_d = ram_addr_o;
        sel_d  = ram_sel_o;
        data_d = ram_data_o;
        if (we_q) begin
          if (cnt_q == LAST_W) begin
            state_d = RESP;
            done_d  = 1'b1;
          end else begin
            ce_d  = 1'b1;
            wen_d = (cnt_d == LAST_W);
          end
        end else if (cnt_d > LAST_W && ram_ready_i) begin
          state_d = RESP;
          done_d  = 1'b1;
          rdata_d = ld_val;
        end else if (cnt_q == LAST_S) begin
          state_d = RESP;
          done_d  = 1'b1;
          berr_d  = 1'b1;
        end else begin
          ce_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= '0;
      sgn_q       <= 1'b0;
      off_q       <= '0;
      ram_ce_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_addr_o  <= '0;
      ram_sel_o   <= '0;
      ram_data_o  <= '0;
      mem_rdata_o <= '0;
      mem_done_o  <= 1'b0;
      misalign_o  <= 1'b0;
      bus_err_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      sgn_q       <= sgn_d;
      off_q       <= off_d;
      ram_ce_o    <= ce_d;
      ram_we_o    <= wen_d;
      ram_addr_o  <= addr_d;
      ram_sel_o   <= sel_d;
      ram_data_o  <= data_d;
      mem_rdata_o <= rdata_d;
      mem_done_o  <= done_d;
      misalign_o  <= mis_d;
      bus_err_o   <= berr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: byte-addressed reference memory,
// random loads/stores, ready delays, timeouts and reset abort.
module tb_mem_access_ctrl;

  localparam int W   = 1;
  localparam int TMO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        mem_req_i, mem_we_i, mem_signed_i;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic        mem_done_o, misalign_o, bus_err_o, stall_req_o;
  logic        ram_ce_o, ram_we_o, ram_ready_i;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  logic [3:0]  ram_sel_o;

  logic        rst_b;
  logic        req_b, we_b, sgn_b;
  logic [1:0]  size_b;
  logic [31:0] addr_b, wdata_b, rdata_b;
  logic        done_b, mis_b, berr_b, stall_b;
  logic        ce_b, wen_b;
  logic [31:0] raddr_b, rdat_b;
  logic [3:0]  sel_b;
  logic [31:0] rdi_b = 32'h0;
  logic        rdy_b = 1'b1;

  mem_access_ctrl #(.WAIT_CYCLES(W), .TIMEOUT(TMO)) u_dut (
    .clk(clk), .rst(rst),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i),
    .mem_size_i(mem_size_i), .mem_signed_i(mem_signed_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_done_o(mem_done_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o),
    .stall_req_o(stall_req_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o),
    .ram_addr_o(ram_addr_o), .ram_sel_o(ram_sel_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
    .ram_ready_i(ram_ready_i)
  );

  mem_access_ctrl #(.WAIT_CYCLES(4), .TIMEOUT(TMO)) u_dut_b (
    .clk(clk), .rst(rst_b),
    .mem_req_i(req_b), .mem_we_i(we_b),
    .mem_size_i(size_b), .mem_signed_i(sgn_b),
    .mem_addr_i(addr_b), .mem_wdata_i(wdata_b),
    .mem_rdata_o(rdata_b), .mem_done_o(done_b),
    .misalign_o(mis_b), .bus_err_o(berr_b),
    .stall_req_o(stall_b),
    .ram_ce_o(ce_b), .ram_we_o(wen_b),
    .ram_addr_o(raddr_b), .ram_sel_o(sel_b),
    .ram_data_o(rdat_b), .ram_data_i(rdi_b),
    .ram_ready_i(rdy_b)
  );

  typedef struct {
    bit          store;
    bit          mis;
    bit          berr;
    logic [31:0] rdata;
    int          lat;
    logic [31:0] waddr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  int          compared = 0;
  int          mismatched = 0;
  logic [7:0]  ref_bytes [256];
  logic [31:0] tb_mem [64];
  int          rdy_delay = 0;
  int          access_cyc = 0;
  int          we_b_cnt = 0;
  int          done_b_cnt = 0;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  assign ram_data_i  = tb_mem[ram_addr_o[7:2]];
  assign ram_ready_i = ram_ce_o && (access_cyc >= rdy_delay);

  always @(posedge clk) access_cyc <= ram_ce_o ? access_cyc + 1 : 0;

  initial begin
    for (int i = 0; i < 64; i++) tb_mem[i] = init_word(i);
    forever begin
      @(negedge clk);
      if (ram_ce_o && ram_we_o)
        for (int l = 0; l < 4; l++)
          if (ram_sel_o[3-l])
            tb_mem[ram_addr_o[7:2]][31-8*l -: 8] = ram_data_o[31-8*l -: 8];
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (wen_b) we_b_cnt++;
      if (done_b) done_b_cnt++;
    end
  end

  initial begin
    int   lat;
    int   wep;
    bit   ce_seen;
    exp_t e;
    lat = 0;
    wep = 0;
    ce_seen = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        lat = 0;
        wep = 0;
        ce_seen = 0;
      end else begin
        if (mem_req_i) begin
          lat++;
          chk("stall", stall_req_o, !mem_done_o);
        end
        if (ram_ce_o) ce_seen = 1;
        if (ram_we_o) begin
          wep++;
          if (sb.size() > 0) begin
            chk("wr_addr", ram_addr_o, sb[0].waddr);
            chk("wr_sel", ram_sel_o, sb[0].sel);
            chk("wr_data", ram_data_o, sb[0].wdata);
          end
        end
        if (mem_done_o) begin
          if (sb.size() == 0) begin
            chk("spurious_done", mem_done_o, 0);
          end else begin
            e = sb.pop_front();
            chk("misalign", misalign_o, e.mis);
            chk("bus_err", bus_err_o, e.berr);
            chk("latency", 32'(lat), 32'(e.lat));
            chk("we_pulses", 32'(wep), (e.store && !e.mis) ? 1 : 0);
            if (e.mis) chk("ce_on_misalign", ce_seen, 0);
            if (!e.store && !e.mis) chk("rdata", mem_rdata_o, e.rdata);
          end
          lat = 0;
          wep = 0;
          ce_seen = 0;
        end
      end
    end
  end

  task automatic issue(input bit we, input logic [1:0] size, input bit sgn,
                       input logic [7:0] a, input logic [31:0] wd,
                       input int dly);
    exp_t        e;
    int          n;
    int          first;
    int          lane;
    bit          got;
    logic [31:0] val;
    e = '{default: 0};
    n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    e.store = we;
    e.mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
    e.waddr = {24'h0, a[7:2], 2'b00};
    if (e.mis) begin
      e.lat = 1;
    end else if (we) begin
      e.lat = W + 1;
      for (int i = 0; i < n; i++) begin
        ref_bytes[8'(int'(a) + i)] = wd[8*(n-1-i) +: 8];
        lane = int'(a[1:0]) + i;
        e.sel[3-lane] = 1'b1;
      end
      e.wdata = (n == 1) ? {4{wd[7:0]}} : (n == 2) ? {2{wd[15:0]}} : wd;
    end else begin
      first = (dly > W - 1) ? dly : W - 1;
      if (first > W + TMO - 2) begin
        e.berr = 1;
        e.lat = W + TMO;
        e.rdata = 0;
      end else begin
        e.lat = first + 2;
        val = 0;
        for (int i = 0; i < n; i++)
          val = (val << 8) | 32'(ref_bytes[8'(int'(a) + i)]);
        if (sgn && n < 4 && val[8*n-1]) val = val | ~((32'd1 << (8*n)) - 1);
        e.rdata = val;
      end
    end
    if (mem_req_i) e.lat++;
    sb.push_back(e);
    rdy_delay    = dly;
    mem_we_i     = we;
    mem_size_i   = size;
    mem_signed_i = sgn;
    mem_addr_i   = {24'h0, a};
    mem_wdata_i  = wd;
    mem_req_i    = 1'b1;
    got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      got = mem_done_o;
    end
    chk("done_timeout", got, 1);
  endtask

  task automatic idle(input int n);
    mem_req_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [31:0] w;
    logic [1:0]  sz;
    logic [7:0]  a;
    int          dly;
    for (int i = 0; i < 64; i++) begin
      w = init_word(i);
      for (int k = 0; k < 4; k++) ref_bytes[4*i+k] = w[31-8*k -: 8];
    end
    rst = 1'b0;
    rst_b = 1'b0;
    mem_req_i = 0; mem_we_i = 0; mem_size_i = 0; mem_signed_i = 0;
    mem_addr_i = 0; mem_wdata_i = 0;
    req_b = 0; we_b = 0; size_b = 0; sgn_b = 0; addr_b = 0; wdata_b = 0;
    repeat (3) @(negedge clk);
    chk("rst_ce", ram_ce_o, 0);
    chk("rst_we", ram_we_o, 0);
    chk("rst_done", mem_done_o, 0);
    chk("rst_rdata", mem_rdata_o, 0);
    chk("rst_sel", ram_sel_o, 0);
    chk("rst_addr", ram_addr_o, 0);
    chk("rst_stall", stall_req_o, 0);
    rst = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);

    req_b = 1; we_b = 1; size_b = 2'b10; addr_b = 32'h40;
    wdata_b = 32'h55AA55AA;
    @(negedge clk);
    chk("b_ce_access", ce_b, 1);
    @(negedge clk);
    rst_b = 1'b0;
    req_b = 0;
    @(negedge clk);
    chk("b_rst_ce", ce_b, 0);
    chk("b_rst_we", wen_b, 0);
    chk("b_rst_done", done_b, 0);
    chk("b_rst_sel", sel_b, 0);
    chk("b_rst_addr", raddr_b, 0);
    chk("b_rst_data", rdat_b, 0);
    chk("b_rst_stall", stall_b, 0);
    rst_b = 1'b1;
    repeat (8) @(negedge clk);
    chk("b_we_pulses", 32'(we_b_cnt), 0);
    chk("b_done_pulses", 32'(done_b_cnt), 0);

    issue(1, 2'b10, 0, 8'h20, 32'h11223344, 0); idle(1);
    issue(1, 2'b00, 0, 8'h21, 32'h000000F2, 0); idle(1);
    issue(0, 2'b00, 1, 8'h21, 32'h0, 0);
    issue(0, 2'b00, 0, 8'h21, 32'h0, 0);        idle(1);
    issue(1, 2'b01, 0, 8'h22, 32'h0000BEEF, 0); idle(1);
    issue(0, 2'b01, 0, 8'h22, 32'h0, 2);        idle(1);
    issue(0, 2'b10, 0, 8'h06, 32'h0, 0);
    issue(1, 2'b01, 0, 8'h03, 32'h1234, 0);     idle(2);
    issue(0, 2'b10, 0, 8'h24, 32'h0, 99);       idle(2);

    for (int r = 0; r < 80; r++) begin
      sz = 2'($urandom_range(0, 3));
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz[1]) a[1:0] = 2'b00;
      end
      dly = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
      issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a,
            $urandom, dly);
      if ($urandom_range(0, 1) != 0) idle(int'($urandom_range(1, 3)));
    end
    idle(4);
    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual no finish required finish");
    $fatal(1);
  end

endmodule
